// File: rtl/arb_pkg.sv
// Shared definitions for the N-channel request/grant arbiter.
//   arb_state_e : controller state (IDLE, GRANT)
//   ARB_FIXED / ARB_RR : arbitration mode selectors fed to arb_pick
//   arb_wrap_inc : modulo-N increment used for the round-robin pointer
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // (v + 1) mod n without a divider; v is always < n.
  function automatic int arb_wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection.
//   req    : raw request vector
//   mask   : channels excluded from this pick (bit set = excluded)
//   ptr    : round-robin search start (ignored in fixed mode)
//   mode   : ARB_FIXED = lowest index wins, ARB_RR = first set bit at/after ptr
//   win    : one-hot winner (all zero when nothing eligible)
//   win_id : index of the winner (0 when nothing eligible)
//   any    : at least one eligible request
module arb_pick
  import arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  input  logic           mode,
  output logic [N-1:0]   win,
  output logic [IDW-1:0] win_id,
  output logic           any
);

  logic [N-1:0] cand;
  int           start;

  assign cand  = req & ~mask;
  assign start = (mode == ARB_RR) ? int'(ptr) : 0;

  // Wrapping search done as two linear passes: first the indices at or
  // above the start point, then everything from 0. The second pass only
  // matters when nothing was found in the first, which is exactly the
  // wrap-around case, so non-power-of-2 N needs no special handling.
  always_comb begin
    win    = '0;
    win_id = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && cand[i] && (i >= start)) begin
        any    = 1'b1;
        win_id = IDW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && cand[i]) begin
        any    = 1'b1;
        win_id = IDW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (any && (win_id == IDW'(i))) win[i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-channel request/grant arbiter with registered one-hot grants.
//   clk       : rising-edge clock
//   rst_n     : active-low reset, asserted asynchronously, released on clk
//   req       : request vector, bit i = requester i
//   gnt       : registered one-hot grant, zero when idle
//   gnt_id    : index of the granted requester, holds last value when idle
//   gnt_valid : |gnt, registered
// Parameters: N channels, MODE (0 fixed priority, 1 round-robin),
// HOLD (owner keeps grant while requesting), MAX_HOLD (burst limit, 0 = none).
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MODE     = 1,
  parameter  int HOLD     = 1,
  parameter  int MAX_HOLD = 0,
  localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  localparam int   HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int   CNTW     = (HW > IDW) ? HW : IDW;
  localparam int   LIMIT    = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic MODE_SEL = (MODE != 0) ? ARB_RR : ARB_FIXED;

  // Reset synchroniser: assertion reaches the state immediately, release
  // is delayed two edges so no flop leaves reset on a metastable edge.
  logic [1:0] rst_sync_q;
  logic       arst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign arst_n = rst_sync_q[1];

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           gnt_valid_q, gnt_valid_d;

  logic           owner_req;
  logic           others_req;
  logic           limit_hit;
  logic           hold_owner;
  logic [N-1:0]   pick_mask;
  logic [N-1:0]   pick_win;
  logic [IDW-1:0] pick_id;
  logic           pick_any;
  logic           take_pick;

  // gnt_q is one-hot, so masking req with it tells whether the owner is
  // still requesting without indexing by gnt_id.
  assign owner_req  = |(req & gnt_q);
  assign others_req = |(req & ~gnt_q);
  assign limit_hit  = (MAX_HOLD > 0) && (cnt_q == CNTW'(LIMIT));
  assign hold_owner = (HOLD != 0) && (state_q == GRANT) && owner_req;

  // Only the burst-limit hand-over excludes the current owner; every other
  // pick sees the full request vector.
  assign pick_mask = (hold_owner && limit_hit) ? gnt_q : '0;

  arb_pick #(
    .N (N)
  ) u_pick (
    .req    (req),
    .mask   (pick_mask),
    .ptr    (ptr_q),
    .mode   (MODE_SEL),
    .win    (pick_win),
    .win_id (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    gnt_id_d  = gnt_id_q;
    take_pick = 1'b0;

    if (hold_owner) begin
      if (!limit_hit) begin
        gnt_d = gnt_q;
        if (MAX_HOLD > 0) cnt_d = cnt_q + CNTW'(1);
      end else if (others_req) begin
        take_pick = 1'b1;
      end else begin
        // Nobody else wants the resource: the owner starts a fresh burst.
        gnt_d = gnt_q;
        cnt_d = '0;
      end
    end else begin
      // Idle, non-holding mode, or the owner released: pick in the same
      // cycle so a hand-over never inserts an idle bubble.
      take_pick = 1'b1;
    end

    if (take_pick) begin
      if (pick_any) begin
        state_d  = GRANT;
        gnt_d    = pick_win;
        gnt_id_d = pick_id;
        cnt_d    = '0;
        ptr_d    = IDW'(arb_wrap_inc(int'(pick_id), N));
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign gnt_valid_d = |gnt_d;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: six configurations run side by side.
//   u0 N=4 RR  no-hold        u1 N=4 fixed no-hold
//   u2 N=4 RR  hold unlimited u3 N=4 RR    hold MAX_HOLD=3
//   u4 N=5 RR  no-hold        u5 N=3 fixed hold MAX_HOLD=2
module tb_rr_arbiter_n;

  localparam int NU = 6;

  int cn[NU] = '{4, 4, 4, 4, 5, 3};
  int cm[NU] = '{1, 0, 1, 1, 1, 0};
  int ch[NU] = '{0, 0, 1, 1, 0, 1};
  int cx[NU] = '{0, 0, 0, 3, 0, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rq[NU];

  logic [3:0] g0, g1, g2, g3;
  logic [4:0] g4;
  logic [2:0] g5;
  logic [1:0] i0, i1, i2, i3, i5;
  logic [2:0] i4;
  logic       v0, v1, v2, v3, v4, v5;

  logic [15:0] o_gnt[NU];
  logic [3:0]  o_id[NU];
  logic        o_vld[NU];

  rr_arbiter_n #(.N(4), .MODE(1), .HOLD(0), .MAX_HOLD(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(rq[0][3:0]), .gnt(g0), .gnt_id(i0), .gnt_valid(v0));
  rr_arbiter_n #(.N(4), .MODE(0), .HOLD(0), .MAX_HOLD(0)) u1 (
    .clk(clk), .rst_n(rst_n), .req(rq[1][3:0]), .gnt(g1), .gnt_id(i1), .gnt_valid(v1));
  rr_arbiter_n #(.N(4), .MODE(1), .HOLD(1), .MAX_HOLD(0)) u2 (
    .clk(clk), .rst_n(rst_n), .req(rq[2][3:0]), .gnt(g2), .gnt_id(i2), .gnt_valid(v2));
  rr_arbiter_n #(.N(4), .MODE(1), .HOLD(1), .MAX_HOLD(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req(rq[3][3:0]), .gnt(g3), .gnt_id(i3), .gnt_valid(v3));
  rr_arbiter_n #(.N(5), .MODE(1), .HOLD(0), .MAX_HOLD(0)) u4 (
    .clk(clk), .rst_n(rst_n), .req(rq[4][4:0]), .gnt(g4), .gnt_id(i4), .gnt_valid(v4));
  rr_arbiter_n #(.N(3), .MODE(0), .HOLD(1), .MAX_HOLD(2)) u5 (
    .clk(clk), .rst_n(rst_n), .req(rq[5][2:0]), .gnt(g5), .gnt_id(i5), .gnt_valid(v5));

  assign o_gnt[0] = 16'(g0);  assign o_id[0] = 4'(i0);  assign o_vld[0] = v0;
  assign o_gnt[1] = 16'(g1);  assign o_id[1] = 4'(i1);  assign o_vld[1] = v1;
  assign o_gnt[2] = 16'(g2);  assign o_id[2] = 4'(i2);  assign o_vld[2] = v2;
  assign o_gnt[3] = 16'(g3);  assign o_id[3] = 4'(i3);  assign o_vld[3] = v3;
  assign o_gnt[4] = 16'(g4);  assign o_id[4] = 4'(i4);  assign o_vld[4] = v4;
  assign o_gnt[5] = 16'(g5);  assign o_id[5] = 4'(i5);  assign o_vld[5] = v5;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the resource, where the round-robin search
  // starts next, and how many extra cycles the owner has held it.
  bit m_vld[NU];
  int m_own[NU];
  int m_ptr[NU];
  int m_cnt[NU];

  function automatic logic [15:0] nmask(input int u);
    return 16'((1 << cn[u]) - 1);
  endfunction

  function automatic int mpick(input int u, input logic [15:0] r);
    int i;
    for (int k = 0; k < cn[u]; k++) begin
      i = (cm[u] != 0) ? (m_ptr[u] + k) % cn[u] : k;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < NU; u++) begin
      m_vld[u] = 1'b0; m_own[u] = 0; m_ptr[u] = 0; m_cnt[u] = 0;
    end
  endtask

  task automatic model_step(input int u, input logic [15:0] rin);
    logic [15:0] r, others;
    int w;
    bit keep;
    r = rin & nmask(u);
    w = -1;
    keep = 1'b0;
    if (m_vld[u] && ch[u] != 0 && r[m_own[u]]) begin
      if (cx[u] > 0 && m_cnt[u] == cx[u] - 1) begin
        others = r;
        others[m_own[u]] = 1'b0;
        if (others != 16'h0) w = mpick(u, others);
        else begin keep = 1'b1; m_cnt[u] = 0; end
      end else begin
        keep = 1'b1;
        m_cnt[u]++;
      end
    end else begin
      w = mpick(u, r);
    end
    if (!keep) begin
      if (w >= 0) begin
        m_vld[u] = 1'b1; m_own[u] = w; m_cnt[u] = 0; m_ptr[u] = (w + 1) % cn[u];
      end else begin
        m_vld[u] = 1'b0;
      end
    end
  endtask

  task automatic set_all(input logic [15:0] r);
    @(negedge clk);
    for (int u = 0; u < NU; u++) rq[u] = r & nmask(u);
  endtask

  task automatic tick();
    for (int u = 0; u < NU; u++) model_step(u, rq[u]);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    set_all(16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin set_all(16'h0); tick(); end
  endtask

  task automatic test_reset();
    do_reset();
    for (int u = 0; u < NU; u++) begin
      checks++;
      if ({o_gnt[u], o_id[u], o_vld[u]} !== 21'h0) begin
        errors++;
        $display("FAIL reset_idle u%0d: got gnt=%h id=%0d vld=%b, expected all zero",
                 u, o_gnt[u], o_id[u], o_vld[u]);
      end
    end
    set_all(16'hF); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    for (int u = 0; u < NU; u++) begin
      checks++;
      if ({o_gnt[u], o_id[u], o_vld[u]} !== 21'h0) begin
        errors++;
        $display("FAIL reset_async u%0d: got gnt=%h id=%0d vld=%b, expected all zero",
                 u, o_gnt[u], o_id[u], o_vld[u]);
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin set_all(16'h0); tick(); end
    set_all(16'hF); tick();
    for (int u = 0; u < NU; u++) begin
      checks++;
      if (o_gnt[u] !== 16'h1 || o_id[u] !== 4'd0 || o_vld[u] !== 1'b1) begin
        errors++;
        $display("FAIL reset_first_grant u%0d: got gnt=%h id=%0d vld=%b, expected gnt=0001 id=0 vld=1",
                 u, o_gnt[u], o_id[u], o_vld[u]);
      end
    end
  endtask

  task automatic test_rr_fair();
    int e_all[6] = '{0, 1, 2, 3, 0, 1};
    int e_alt[4] = '{1, 3, 1, 3};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_all(16'hF); tick();
      checks++;
      if (o_id[0] !== 4'(e_all[k]) || o_gnt[0] !== (16'h1 << e_all[k]) || o_vld[0] !== 1'b1) begin
        errors++;
        $display("FAIL rr_1111 cycle %0d: got id=%0d gnt=%h vld=%b, expected id=%0d",
                 k, o_id[0], o_gnt[0], o_vld[0], e_all[k]);
      end
    end
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_all(16'hA); tick();
      checks++;
      if (o_id[0] !== 4'(e_alt[k]) || o_gnt[0] !== (16'h1 << e_alt[k])) begin
        errors++;
        $display("FAIL rr_1010 cycle %0d: got id=%0d gnt=%h, expected id=%0d",
                 k, o_id[0], o_gnt[0], e_alt[k]);
      end
    end
  endtask

  task automatic test_rr_wrap_n5();
    int e5[6] = '{0, 1, 2, 3, 4, 0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_all(16'h1F); tick();
      checks++;
      if (o_id[4] !== 4'(e5[k]) || o_gnt[4] !== (16'h1 << e5[k])) begin
        errors++;
        $display("FAIL rr_wrap_n5 cycle %0d: got id=%0d gnt=%h, expected id=%0d",
                 k, o_id[4], o_gnt[4], e5[k]);
      end
    end
  endtask

  task automatic test_fixed();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_all(16'hA); tick();
      checks++;
      if (o_id[1] !== 4'd1 || o_gnt[1] !== 16'h2) begin
        errors++;
        $display("FAIL fixed_1010 cycle %0d: got id=%0d gnt=%h, expected id=1 gnt=0002",
                 k, o_id[1], o_gnt[1]);
      end
    end
    set_all(16'hB); tick();
    checks++;
    if (o_id[1] !== 4'd0 || o_gnt[1] !== 16'h1) begin
      errors++;
      $display("FAIL fixed_raise0: got id=%0d gnt=%h, expected id=0 gnt=0001", o_id[1], o_gnt[1]);
    end
  endtask

  task automatic test_hold_unlimited();
    do_reset();
    set_all(16'h1); tick();
    checks++;
    if (o_gnt[2] !== 16'h1) begin
      errors++;
      $display("FAIL hold_first: got gnt=%h, expected 0001", o_gnt[2]);
    end
    for (int k = 0; k < 5; k++) begin
      set_all(16'h5); tick();
      checks++;
      if (o_gnt[2] !== 16'h1 || o_vld[2] !== 1'b1) begin
        errors++;
        $display("FAIL hold_keep cycle %0d: got gnt=%h vld=%b, expected gnt=0001 vld=1",
                 k, o_gnt[2], o_vld[2]);
      end
    end
    set_all(16'h4); tick();
    checks++;
    if (o_gnt[2] !== 16'h4 || o_id[2] !== 4'd2 || o_vld[2] !== 1'b1) begin
      errors++;
      $display("FAIL hold_handover: got gnt=%h id=%0d vld=%b, expected gnt=0004 id=2 vld=1",
               o_gnt[2], o_id[2], o_vld[2]);
    end
  endtask

  task automatic test_bounded_hold();
    int eb[7] = '{0, 0, 0, 1, 1, 1, 0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      set_all(16'h3); tick();
      checks++;
      if (o_id[3] !== 4'(eb[k]) || o_gnt[3] !== (16'h1 << eb[k]) || o_vld[3] !== 1'b1) begin
        errors++;
        $display("FAIL bounded_hold cycle %0d: got id=%0d gnt=%h vld=%b, expected id=%0d",
                 k, o_id[3], o_gnt[3], o_vld[3], eb[k]);
      end
    end
  endtask

  task automatic test_lone_owner();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_all(16'h4); tick();
      checks++;
      if (o_id[3] !== 4'd2 || o_gnt[3] !== 16'h4 || o_vld[3] !== 1'b1) begin
        errors++;
        $display("FAIL lone_owner cycle %0d: got id=%0d gnt=%h vld=%b, expected id=2 gnt=0004 vld=1",
                 k, o_id[3], o_gnt[3], o_vld[3]);
      end
    end
    set_all(16'h0); tick();
    checks++;
    if (o_vld[3] !== 1'b0 || o_gnt[3] !== 16'h0 || o_id[3] !== 4'd2) begin
      errors++;
      $display("FAIL idle_after_drop: got id=%0d gnt=%h vld=%b, expected id=2 gnt=0000 vld=0",
               o_id[3], o_gnt[3], o_vld[3]);
    end
  endtask

  task automatic test_random();
    logic [15:0] eg;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int u = 0; u < NU; u++) begin
        if ($urandom_range(0, 3) == 0) begin
          rq[u] = 16'($urandom) & nmask(u);
          if ($urandom_range(0, 1) == 1) rq[u] = rq[u] & 16'($urandom);
        end
      end
      tick();
      for (int u = 0; u < NU; u++) begin
        eg = m_vld[u] ? (16'h1 << m_own[u]) : 16'h0;
        checks++;
        if (o_gnt[u] !== eg || o_id[u] !== 4'(m_own[u]) || o_vld[u] !== m_vld[u]) begin
          errors++;
          $display("FAIL random u%0d cycle %0d: got gnt=%h id=%0d vld=%b, expected gnt=%h id=%0d vld=%b",
                   u, c, o_gnt[u], o_id[u], o_vld[u], eg, m_own[u], m_vld[u]);
        end
      end
    end
  endtask

  initial begin
    for (int u = 0; u < NU; u++) rq[u] = 16'h0;
    test_reset();
    test_rr_fair();
    test_rr_wrap_n5();
    test_fixed();
    test_hold_unlimited();
    test_bounded_hold();
    test_lone_owner();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
